// File: rtl/afg_pkg.sv
// Shared definitions for the arbitrary function generator address sequencer:
// default widths/latency, the sequencer state encoding and the burst-length
// substitution constant.
package afg_pkg;

    localparam int ADDR_W_DEF   = 14;
    localparam int ACC_W_DEF    = 32;
    localparam int BURST_W_DEF  = 16;
    localparam int PIPE_LAT_DEF = 3;

    // A requested burst length of zero plays this many periods instead.
    localparam int BURST_LEN_ZERO_SUB = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage

// File: rtl/afg_valid_delay.sv
// Fixed-depth 1-bit delay line with asynchronous reset. Used to align
// per-address flags with the output of the downstream address buffer pipeline.
module afg_valid_delay
    import afg_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] taps;

    // Shift the input flag one stage per clock; reset empties the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= '0;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/afg_addr_sequencer.sv
// Phase-accumulator address sequencer for the arbitrary function generator.
// Generates waveform-memory addresses for continuous or burst playback and
// a valid flag aligned with the address buffer pipeline output.
// Optional macro AFG_SEQ_SYNC_OUT_EN adds the SyncOut period-wrap trigger.
module afg_addr_sequencer
    import afg_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int BURST_W  = BURST_W_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stop,
    input  logic               BurstMode,
    input  logic [BURST_W-1:0] BurstLen,
    input  logic [ACC_W-1:0]   TuneWord,
    input  logic [ADDR_W-1:0]  PhaseOff,
    output logic [ADDR_W-1:0]  Addr,
    output logic               AddrValid,
    output logic               DataValid,
    output logic               Busy,
    output logic               Done
`ifdef AFG_SEQ_SYNC_OUT_EN
    ,
    output logic               SyncOut
`endif
);

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);
    localparam logic [BURST_W-1:0] LEN_SUB    = BURST_W'(BURST_LEN_ZERO_SUB);
    localparam logic [BURST_W-1:0] LEN_ONE    = BURST_W'(1);

    seq_state_t         state;
    seq_state_t         state_next;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   tune_q;
    logic               burst_q;
    logic [BURST_W-1:0] len_q;
    logic [BURST_W-1:0] period_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [ADDR_W-1:0]  addr_hold;

    logic [ACC_W:0]     acc_sum;
    logic               wrap;
    logic [ADDR_W-1:0]  acc_addr;
    logic               load;
    logic               period_inc;

    // The carry out of the accumulator add marks the last address of a period.
    assign acc_sum  = {1'b0, acc} + {1'b0, tune_q};
    assign wrap     = acc_sum[ACC_W];
    assign acc_addr = acc[ACC_W-1 -: ADDR_W];

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; Addr shows the accumulator only in RUN
    // and otherwise holds the last address that was played.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        period_inc = 1'b0;
        Addr       = addr_hold;
        AddrValid  = 1'b0;
        Done       = 1'b0;
        Busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (Start && !Stop) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                Addr      = acc_addr;
                AddrValid = 1'b1;
                if (Stop) begin
                    state_next = DRAIN;
                end else if (burst_q && wrap) begin
                    if (period_cnt == (len_q - LEN_ONE)) begin
                        state_next = DRAIN;
                    end else begin
                        period_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    Done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch settings on start, advance the accumulator while
    // running, count burst periods and drain cycles.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc        <= '0;
            tune_q     <= '0;
            burst_q    <= 1'b0;
            len_q      <= '0;
            period_cnt <= '0;
            drain_cnt  <= '0;
            addr_hold  <= '0;
        end else begin
            if (load) begin
                tune_q     <= TuneWord;
                burst_q    <= BurstMode;
                len_q      <= (BurstLen == '0) ? LEN_SUB : BurstLen;
                acc        <= {PhaseOff, {(ACC_W-ADDR_W){1'b0}}};
                period_cnt <= '0;
            end else if (state == RUN) begin
                acc       <= acc_sum[ACC_W-1:0];
                addr_hold <= acc_addr;
                if (period_inc) begin
                    period_cnt <= period_cnt + LEN_ONE;
                end
            end
            if (state == DRAIN) begin
                drain_cnt <= drain_cnt + DRAIN_W'(1);
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    afg_valid_delay #(
        .DEPTH(PIPE_LAT)
    ) u_data_valid_delay (
        .clk (Clock),
        .rst (Reset),
        .din (AddrValid),
        .dout(DataValid)
    );

`ifdef AFG_SEQ_SYNC_OUT_EN
    logic wrap_pulse;

    assign wrap_pulse = (state == RUN) && wrap;

    afg_valid_delay #(
        .DEPTH(PIPE_LAT)
    ) u_sync_delay (
        .clk (Clock),
        .rst (Reset),
        .din (wrap_pulse),
        .dout(SyncOut)
    );
`endif

endmodule

// File: tb/tb_afg_addr_sequencer.sv
// Directed self-checking bench for afg_addr_sequencer. Define
// AFG_SEQ_SYNC_OUT_EN for both bench and RTL to include the SyncOut checks.
module tb_afg_addr_sequencer;

    localparam int ADDR_W   = 14;
    localparam int ACC_W    = 32;
    localparam int BURST_W  = 16;
    localparam int PIPE_LAT = 3;

    logic               Clock = 1'b0;
    logic               Reset;
    logic               Start;
    logic               Stop;
    logic               BurstMode;
    logic [BURST_W-1:0] BurstLen;
    logic [ACC_W-1:0]   TuneWord;
    logic [ADDR_W-1:0]  PhaseOff;
    logic [ADDR_W-1:0]  Addr;
    logic               AddrValid;
    logic               DataValid;
    logic               Busy;
    logic               Done;
`ifdef AFG_SEQ_SYNC_OUT_EN
    logic               SyncOut;
`endif

    int checks   = 0;
    int failures = 0;

    afg_addr_sequencer #(
        .ADDR_W  (ADDR_W),
        .ACC_W   (ACC_W),
        .BURST_W (BURST_W),
        .PIPE_LAT(PIPE_LAT)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Stop     (Stop),
        .BurstMode(BurstMode),
        .BurstLen (BurstLen),
        .TuneWord (TuneWord),
        .PhaseOff (PhaseOff),
        .Addr     (Addr),
        .AddrValid(AddrValid),
        .DataValid(DataValid),
        .Busy     (Busy),
        .Done     (Done)
`ifdef AFG_SEQ_SYNC_OUT_EN
        ,
        .SyncOut  (SyncOut)
`endif
    );

    always #5 Clock = ~Clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Request start; on return we sit in the first RUN cycle.
    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (!Busy) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0; Stop = 1'b0; BurstMode = 1'b0;
        BurstLen = '0; TuneWord = '0; PhaseOff = '0;
        tick();
        tick();
        checks++; if (Addr !== 14'h0000) begin failures++; $display("[TB] FAIL reset_addr got=%h exp=0000", Addr); end
        checks++; if (AddrValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_addrvalid got=%b exp=0", AddrValid); end
        checks++; if (DataValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_datavalid got=%b exp=0", DataValid); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", Done); end
        Reset = 1'b0;
        tick();
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy got=%b exp=0", Busy); end
    endtask

    task automatic test_continuous();
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_dv;
        TuneWord = 32'h1000_0000; PhaseOff = '0; BurstMode = 1'b0; BurstLen = '0;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            exp_addr = ADDR_W'(i * 32'h400);
            exp_dv   = (i >= 3);
            checks++; if (Addr !== exp_addr) begin failures++; $display("[TB] FAIL cont_addr i=%0d got=%h exp=%h", i, Addr, exp_addr); end
            checks++; if (AddrValid !== 1'b1) begin failures++; $display("[TB] FAIL cont_addrvalid i=%0d got=%b exp=1", i, AddrValid); end
            checks++; if (DataValid !== exp_dv) begin failures++; $display("[TB] FAIL cont_datavalid i=%0d got=%b exp=%b", i, DataValid, exp_dv); end
            checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL cont_done i=%0d got=%b exp=0", i, Done); end
`ifdef AFG_SEQ_SYNC_OUT_EN
            begin
                logic exp_sync;
                exp_sync = (i >= 18) && (((i - 18) % 16) == 0);
                checks++; if (SyncOut !== exp_sync) begin failures++; $display("[TB] FAIL cont_syncout i=%0d got=%b exp=%b", i, SyncOut, exp_sync); end
            end
`endif
            if (i < 39) tick();
        end
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        for (int d = 0; d < PIPE_LAT; d++) begin
            checks++; if (AddrValid !== 1'b0) begin failures++; $display("[TB] FAIL cont_drain_valid d=%0d got=%b exp=0", d, AddrValid); end
            checks++; if (Addr !== 14'h1C00) begin failures++; $display("[TB] FAIL cont_drain_addr d=%0d got=%h exp=1c00", d, Addr); end
            checks++; if (DataValid !== 1'b1) begin failures++; $display("[TB] FAIL cont_drain_dv d=%0d got=%b exp=1", d, DataValid); end
            checks++; if (Done !== (d == PIPE_LAT - 1)) begin failures++; $display("[TB] FAIL cont_drain_done d=%0d got=%b", d, Done); end
            tick();
        end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL cont_idle_busy got=%b exp=0", Busy); end
        checks++; if (DataValid !== 1'b0) begin failures++; $display("[TB] FAIL cont_idle_dv got=%b exp=0", DataValid); end
        checks++; if (Addr !== 14'h1C00) begin failures++; $display("[TB] FAIL cont_idle_addr got=%h exp=1c00", Addr); end
    endtask

    task automatic test_burst(input logic [BURST_W-1:0] len, input int exp_valid);
        int valid_cnt  = 0;
        int dv_cnt     = 0;
        int last_valid = -1;
        int done_cyc   = -1;
        int done_cnt   = 0;
        int busy_fall  = -1;
        logic [ADDR_W-1:0] last_addr = '0;
        TuneWord = 32'h1000_0000; PhaseOff = '0; BurstMode = 1'b1; BurstLen = len;
        pulse_start();
        for (int c = 0; c < 200; c++) begin
            if (AddrValid) begin valid_cnt++; last_valid = c; last_addr = Addr; end
            if (DataValid) dv_cnt++;
            if (Done) begin done_cnt++; done_cyc = c; end
            if (!Busy) begin busy_fall = c; break; end
            tick();
        end
        checks++; if (busy_fall < 0) begin failures++; $display("[TB] FAIL burst%0d_timeout got=busy exp=idle", len); end
        checks++; if (valid_cnt != exp_valid) begin failures++; $display("[TB] FAIL burst%0d_valid_count got=%0d exp=%0d", len, valid_cnt, exp_valid); end
        checks++; if (dv_cnt != exp_valid) begin failures++; $display("[TB] FAIL burst%0d_dv_count got=%0d exp=%0d", len, dv_cnt, exp_valid); end
        checks++; if (done_cnt != 1) begin failures++; $display("[TB] FAIL burst%0d_done_count got=%0d exp=1", len, done_cnt); end
        checks++; if (done_cyc != last_valid + 3) begin failures++; $display("[TB] FAIL burst%0d_done_cycle got=%0d exp=%0d", len, done_cyc, last_valid + 3); end
        checks++; if (busy_fall != last_valid + 4) begin failures++; $display("[TB] FAIL burst%0d_busy_fall got=%0d exp=%0d", len, busy_fall, last_valid + 4); end
        checks++; if (last_addr !== 14'h3C00) begin failures++; $display("[TB] FAIL burst%0d_last_addr got=%h exp=3c00", len, last_addr); end
        checks++; if (Addr !== 14'h3C00) begin failures++; $display("[TB] FAIL burst%0d_idle_addr got=%h exp=3c00", len, Addr); end
        BurstMode = 1'b0;
    endtask

    task automatic test_stop_mid_run();
        TuneWord = 32'h1000_0000; PhaseOff = '0; BurstMode = 1'b0;
        pulse_start();
        repeat (4) tick();
        checks++; if (Addr !== 14'h1000) begin failures++; $display("[TB] FAIL stop_fifth_addr got=%h exp=1000", Addr); end
        checks++; if (AddrValid !== 1'b1) begin failures++; $display("[TB] FAIL stop_fifth_valid got=%b exp=1", AddrValid); end
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        for (int d = 0; d < PIPE_LAT; d++) begin
            checks++; if (AddrValid !== 1'b0) begin failures++; $display("[TB] FAIL stop_drain_valid d=%0d got=%b exp=0", d, AddrValid); end
            checks++; if (Addr !== 14'h1000) begin failures++; $display("[TB] FAIL stop_drain_addr d=%0d got=%h exp=1000", d, Addr); end
            checks++; if (Busy !== 1'b1) begin failures++; $display("[TB] FAIL stop_drain_busy d=%0d got=%b exp=1", d, Busy); end
            checks++; if (Done !== (d == PIPE_LAT - 1)) begin failures++; $display("[TB] FAIL stop_drain_done d=%0d got=%b", d, Done); end
            tick();
        end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL stop_idle_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL stop_idle_done got=%b exp=0", Done); end
        checks++; if (Addr !== 14'h1000) begin failures++; $display("[TB] FAIL stop_idle_addr got=%h exp=1000", Addr); end
    endtask

    task automatic test_start_stop_same();
        Start = 1'b1; Stop = 1'b1;
        tick();
        Start = 1'b0; Stop = 1'b0;
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL startstop_busy got=%b exp=0", Busy); end
        checks++; if (AddrValid !== 1'b0) begin failures++; $display("[TB] FAIL startstop_valid got=%b exp=0", AddrValid); end
        tick();
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL startstop_busy_later got=%b exp=0", Busy); end
    endtask

    task automatic test_start_in_run();
        logic [ADDR_W-1:0] exp_addr;
        bit ok;
        TuneWord = 32'h1000_0000; PhaseOff = 14'h1234; BurstMode = 1'b0;
        pulse_start();
        checks++; if (Addr !== 14'h1234) begin failures++; $display("[TB] FAIL restart_first_addr got=%h exp=1234", Addr); end
        tick();
        checks++; if (Addr !== 14'h1634) begin failures++; $display("[TB] FAIL restart_second_addr got=%h exp=1634", Addr); end
        TuneWord = 32'h2000_0000; PhaseOff = '0; Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            exp_addr = ADDR_W'(32'h1A34 + k * 32'h400);
            checks++; if (Addr !== exp_addr) begin failures++; $display("[TB] FAIL restart_addr k=%0d got=%h exp=%h", k, Addr, exp_addr); end
            tick();
        end
        Stop = 1'b1;
        tick();
        Stop = 1'b0;
        wait_idle(20, ok);
        checks++; if (!ok) begin failures++; $display("[TB] FAIL restart_drain_timeout got=busy exp=idle"); end
        TuneWord = 32'h1000_0000;
    endtask

    task automatic test_async_reset();
        int done_seen = 0;
        TuneWord = 32'h1000_0000; PhaseOff = 14'h0800; BurstMode = 1'b0;
        pulse_start();
        repeat (5) tick();
        checks++; if (DataValid !== 1'b1) begin failures++; $display("[TB] FAIL areset_pre_dv got=%b exp=1", DataValid); end
        checks++; if (Addr !== 14'h1C00) begin failures++; $display("[TB] FAIL areset_pre_addr got=%h exp=1c00", Addr); end
        #3;
        Reset = 1'b1;
        #1;
        checks++; if (Addr !== 14'h0000) begin failures++; $display("[TB] FAIL areset_addr got=%h exp=0000", Addr); end
        checks++; if (AddrValid !== 1'b0) begin failures++; $display("[TB] FAIL areset_valid got=%b exp=0", AddrValid); end
        checks++; if (DataValid !== 1'b0) begin failures++; $display("[TB] FAIL areset_dv got=%b exp=0", DataValid); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL areset_busy got=%b exp=0", Busy); end
        checks++; if (Done !== 1'b0) begin failures++; $display("[TB] FAIL areset_done got=%b exp=0", Done); end
        tick();
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (Done || Busy) done_seen++;
            tick();
        end
        checks++; if (done_seen != 0) begin failures++; $display("[TB] FAIL areset_after_activity got=%0d exp=0", done_seen); end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Stop = 1'b0; BurstMode = 1'b0;
        BurstLen = '0; TuneWord = '0; PhaseOff = '0;
        test_reset();
        test_continuous();
        test_burst(16'd2, 32);
        test_burst(16'd0, 16);
        test_stop_mid_run();
        test_start_stop_same();
        test_start_in_run();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=running exp=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/afg_addr_sequencer.md
Name: afg_addr_sequencer

Overview:
- Phase-accumulator address sequencer for the arbitrary function generator.
- Drives the 14-bit waveform-memory address into the existing 3-stage address buffer pipeline. Produces a valid flag aligned with the buffer output so downstream DAC logic can qualify samples.
- Supports continuous playback, or a burst of N whole waveform periods with start/stop control.

Parameters:
- ADDR_W, 14, waveform address width (top bits of accumulator).
- ACC_W, 32, phase accumulator / tuning word width; must be > ADDR_W.
- BURST_W, 16, burst period counter width.
- PIPE_LAT, 3, latency in clocks of the downstream address buffer pipeline.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle start request.
- Stop  in  1  single-cycle abort request.
- BurstMode  in  1  1 = burst of BurstLen periods, 0 = continuous.
- BurstLen  in  BURST_W  number of full periods per burst; 0 is treated as 1.
- TuneWord  in  ACC_W  phase increment per clock.
- PhaseOff  in  ADDR_W  start address (phase offset).
- Addr  out  ADDR_W  address to buffer pipeline Din.
- AddrValid  out  1  Addr is an active sample this cycle.
- DataValid  out  1  AddrValid delayed PIPE_LAT clocks, aligned with buffer Dout.
- Busy  out  1  state != IDLE.
- Done  out  1  one-cycle pulse at end of playback.

Behaviour:
- Reset (async, active-high): state = IDLE, acc = 0, Addr = 0, all flags = 0, period count = 0, valid delay line cleared. Reset mid-run aborts immediately with no Done pulse.
- States: IDLE, RUN, DRAIN.
- IDLE, Start=1 and Stop=0:
  - latch TuneWord, BurstMode and BurstLen (0 becomes 1);
  - load acc = {PhaseOff, zeros};
  - go to RUN.
- IDLE with Start=1 and Stop=1: Stop wins; remain in IDLE.
- RUN, each cycle:
  - Addr = acc[ACC_W-1:ACC_W-ADDR_W] and AddrValid = 1;
  - acc <= acc + TuneWord, modulo 2^ACC_W; the carry-out marks a period wrap.
- RUN timing: with Start sampled at edge k, the first AddrValid cycle is k+1 with Addr = PhaseOff.
- Burst end: in a burst, on a wrap cycle where period count == BurstLen-1, that cycle's Addr is the last valid one. Next state is DRAIN. Otherwise a wrap increments the period count.
- Continuous mode: wraps are ignored; playback runs until Stop.
- Stop in RUN: the current cycle's Addr is still valid. Next state is DRAIN with AddrValid = 0.
- Start in RUN or DRAIN is ignored; inputs are not re-latched.
- DRAIN: lasts exactly PIPE_LAT cycles.
  - AddrValid = 0; Addr holds its last value so there is no glitch into the DAC path.
  - Done = 1 in the final DRAIN cycle, coincident with the last DataValid. Next state is IDLE.
- Addr holds its last value in IDLE; it does not return to 0.
- DataValid is a PIPE_LAT-deep shift of AddrValid and is cleared only by Reset.
- Busy is high in RUN and DRAIN.
- TuneWord = 0: the address is static and a burst never completes; only Stop or Reset ends playback. This is legal.

Optional Feature:
- Macro: AFG_SEQ_SYNC_OUT_EN.
- With the macro defined: adds output port SyncOut (1 bit), a one-cycle pulse for each period wrap in RUN. It is delayed PIPE_LAT clocks so it aligns with DataValid, for use as a scope trigger.
- Without the macro: the port and its delay logic are absent; all other behaviour is identical.

Decomposition:
- Package afg_pkg holds:
  - ADDR_W/ACC_W/PIPE_LAT defaults;
  - the sequencer state enum (IDLE, RUN, DRAIN);
  - the constant for the burst-length-zero substitution.
- One sub-module: afg_valid_delay, a parameterised PIPE_LAT-deep 1-bit shift register with async reset. It is instantiated for DataValid, and for SyncOut when enabled.

Test Plan:
- Continuous run: TuneWord=0x10000000, PhaseOff=0, BurstMode=0, Start at cycle 0.
  - Addr sequence from cycle 1 is 0x0000, 0x0400, …, 0x3C00, 0x0000.
  - DataValid first rises at cycle 4.
- Burst: TuneWord=0x10000000, BurstLen=2.
  - Exactly 32 AddrValid cycles.
  - Done pulses 3 cycles after the last AddrValid, with Busy falling the cycle after.
- Stop mid-run: Stop at the 5th RUN cycle.
  - That cycle is the last AddrValid; Done pulses 3 cycles later.
  - Addr holds 0x1000 (PhaseOff=0, step 0x400).
- Edge cases:
  - Start+Stop in the same IDLE cycle leaves Busy=0.
  - Start during RUN does not change TuneWord.
  - BurstLen=0 plays 1 period (16 valid cycles).
- Reset asserted mid-RUN, asynchronously between edges: Addr, AddrValid, DataValid, Busy and Done go to 0 immediately, with no Done pulse.
- With AFG_SEQ_SYNC_OUT_EN, TuneWord=0x10000000: SyncOut pulses every 16 cycles, aligned with DataValid.
